// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads the IF/ID register.
// Optional IF_FETCH_COUNT_EN adds a 32-bit count of valid IF/ID loads on output fetch_count.
`ifndef INSTRUCTION_LEN
`define INSTRUCTION_LEN 32
`endif
`ifndef INSTRUCTION_MEM_SIZE
`define INSTRUCTION_MEM_SIZE 1024
`endif

module if_stage #(
  parameter int INSTR_WIDTH = `INSTRUCTION_LEN,
  parameter int MEM_WORDS   = `INSTRUCTION_MEM_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [INSTR_WIDTH-1:0] branch_addr,
  input  logic [INSTR_WIDTH-1:0] mem_read_data,
  output logic [INSTR_WIDTH-1:0] mem_addr,
  output logic                   mem_read,
`ifdef IF_FETCH_COUNT_EN
  output logic [31:0]            fetch_count,
`endif
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [INSTR_WIDTH-1:0] pc,
  output logic                   valid
);

  localparam logic [INSTR_WIDTH:0]   MEM_WORDS_W = (INSTR_WIDTH + 1)'(MEM_WORDS);
  localparam logic [INSTR_WIDTH-1:0] PC_STEP     = INSTR_WIDTH'(4);

  logic [INSTR_WIDTH-1:0] pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [INSTR_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] word_idx;
  logic [INSTR_WIDTH-1:0] pc_plus4;
  logic                   in_range;
  logic [1:0]             unused_branch_lsbs;

  assign word_idx           = pc_q >> 2;
  assign pc_plus4           = pc_q + PC_STEP;
  assign in_range           = ({1'b0, word_idx} < MEM_WORDS_W);
  assign unused_branch_lsbs = branch_addr[1:0];

  assign mem_addr = word_idx;
  assign mem_read = rst & in_range;
  assign instr    = instr_q;
  assign pc       = ifid_pc_q;
  assign valid    = valid_q;

  // Branch outranks freeze so a redirect is never lost behind a stall.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    ifid_pc_d = ifid_pc_q;
    valid_d   = valid_q;
    if (branch_taken) begin
      pc_d      = {branch_addr[INSTR_WIDTH-1:2], 2'b00};
      instr_d   = '0;
      ifid_pc_d = '0;
      valid_d   = 1'b0;
    end else if (!freeze) begin
      pc_d      = pc_plus4;
      instr_d   = mem_read ? mem_read_data : '0;
      ifid_pc_d = pc_plus4;
      valid_d   = mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= '0;
      instr_q   <= '0;
      ifid_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      ifid_pc_q <= ifid_pc_d;
      valid_q   <= valid_d;
    end
  end

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (!branch_taken && !freeze && mem_read) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a reference model pushes expected IF/ID state per edge, popped after the edge.
`timescale 1ns/1ps
module tb_if_stage;

  localparam int W    = 32;
  localparam int MEMW = 16;

  typedef struct {
    logic [W-1:0] instr;
    logic [W-1:0] pc;
    logic         valid;
    logic [W-1:0] mem_addr;
    logic [31:0]  cnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         freeze = 1'b0;
  logic         branch_taken = 1'b0;
  logic [W-1:0] branch_addr = '0;
  logic [W-1:0] mem_read_data;
  logic [W-1:0] mem_addr;
  logic         mem_read;
  logic [W-1:0] instr;
  logic [W-1:0] pc;
  logic         valid;
`ifdef IF_FETCH_COUNT_EN
  logic [31:0]  fetch_count;
`endif

  logic [W-1:0] tb_mem [MEMW];
  exp_t         sb_q[$];

  logic [W-1:0] m_pc, m_instr, m_pcout;
  logic         m_valid;
  logic [31:0]  m_cnt;
  int           n_pass  = 0;
  int           n_total = 0;

  always #5 clk = ~clk;

  assign mem_read_data = (mem_read && mem_addr < MEMW) ? tb_mem[mem_addr[3:0]] : '0;

  if_stage #(.INSTR_WIDTH(W), .MEM_WORDS(MEMW)) dut (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .branch_taken(branch_taken),
    .branch_addr(branch_addr),
    .mem_read_data(mem_read_data),
    .mem_addr(mem_addr),
    .mem_read(mem_read),
`ifdef IF_FETCH_COUNT_EN
    .fetch_count(fetch_count),
`endif
    .instr(instr),
    .pc(pc),
    .valid(valid)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: drive at negedge, predict, then compare just after the rising edge.
  task automatic step(input string tag, input logic r, input logic f, input logic b, input logic [W-1:0] a);
    exp_t e;
    logic rd;
    @(negedge clk);
    rst = r; freeze = f; branch_taken = b; branch_addr = a;
    #1;
    rd = r && ((m_pc >> 2) < MEMW);
    chk({tag, "_mem_read"}, {31'b0, mem_read}, {31'b0, rd});
    if (!r) begin
      m_pc = '0; m_instr = '0; m_pcout = '0; m_valid = 1'b0; m_cnt = '0;
    end else if (b) begin
      m_pc = {a[W-1:2], 2'b00}; m_instr = '0; m_pcout = '0; m_valid = 1'b0;
    end else if (!f) begin
      m_instr = rd ? tb_mem[m_pc[5:2]] : '0;
      m_pcout = m_pc + 4;
      m_valid = rd;
      m_pc    = m_pc + 4;
      if (rd) m_cnt = m_cnt + 1;
    end
    e.instr = m_instr; e.pc = m_pcout; e.valid = m_valid; e.mem_addr = m_pc >> 2; e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_instr"}, instr, e.instr);
      chk({tag, "_pc"}, pc, e.pc);
      chk({tag, "_valid"}, {31'b0, valid}, {31'b0, e.valid});
      chk({tag, "_mem_addr"}, mem_addr, e.mem_addr);
`ifdef IF_FETCH_COUNT_EN
      chk({tag, "_fetch_count"}, fetch_count, e.cnt);
`endif
    end
  endtask

  initial begin
    tb_mem[0] = 32'h11111111;
    tb_mem[1] = 32'h22222222;
    tb_mem[2] = 32'h33333333;
    tb_mem[3] = 32'h44444444;
    for (int i = 4; i < MEMW; i++) tb_mem[i] = 32'hA0000000 + i;
    m_pc = '0; m_instr = '0; m_pcout = '0; m_valid = 1'b0; m_cnt = '0;

    // Reset and sequential fetch
    step("rst0", 1'b0, 1'b0, 1'b0, '0);
    step("rst1", 1'b0, 1'b0, 1'b0, '0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    step("seq0", 1'b1, 1'b0, 1'b0, '0);
    chk("seq0_const", instr, 32'h11111111); chk("seq0_pc", pc, 32'd4);
    step("seq1", 1'b1, 1'b0, 1'b0, '0);
    chk("seq1_const", instr, 32'h22222222); chk("seq1_pc", pc, 32'd8);
    step("seq2", 1'b1, 1'b0, 1'b0, '0);
    chk("seq2_const", instr, 32'h33333333); chk("seq2_pc", pc, 32'd12);
    step("seq3", 1'b1, 1'b0, 1'b0, '0);
    chk("seq3_const", instr, 32'h44444444); chk("seq3_pc", pc, 32'd16);
`ifdef IF_FETCH_COUNT_EN
    chk("cnt_after_seq", fetch_count, 32'd4);
`endif

    // Freeze for three cycles after the second fetch
    step("frst", 1'b0, 1'b0, 1'b0, '0);
    step("f0", 1'b1, 1'b0, 1'b0, '0);
    step("f1", 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      step("frz", 1'b1, 1'b1, 1'b0, '0);
      chk("frz_instr", instr, 32'h22222222);
      chk("frz_pc", pc, 32'd8);
      chk("frz_mem_addr", mem_addr, 32'd2);
    end
    step("funfrz", 1'b1, 1'b0, 1'b0, '0);
    chk("funfrz_instr", instr, 32'h33333333); chk("funfrz_pc", pc, 32'd12);

    // Branch to unaligned 0xE while pc_reg = 8
    step("brst", 1'b0, 1'b0, 1'b0, '0);
    step("b0", 1'b1, 1'b0, 1'b0, '0);
    step("b1", 1'b1, 1'b0, 1'b0, '0);
    step("br", 1'b1, 1'b0, 1'b1, 32'h0000000E);
    chk("br_valid", {31'b0, valid}, 32'h0);
    chk("br_mem_addr", mem_addr, 32'd3);
    step("br_next", 1'b1, 1'b0, 1'b0, '0);
    chk("br_next_instr", instr, 32'h44444444); chk("br_next_pc", pc, 32'h10);

    // Branch wins over freeze
    step("brfrz", 1'b1, 1'b1, 1'b1, 32'h0);
    chk("brfrz_mem_addr", mem_addr, 32'd0);
    step("brfrz_next", 1'b1, 1'b0, 1'b0, '0);
    chk("brfrz_instr", instr, 32'h11111111);

    // Out-of-range fetch
    step("oor_br", 1'b1, 1'b0, 1'b1, 32'(4 * MEMW));
    step("oor", 1'b1, 1'b0, 1'b0, '0);
    chk("oor_instr", instr, 32'h0);
    chk("oor_valid", {31'b0, valid}, 32'h0);
    chk("oor_mem_addr", mem_addr, 32'(MEMW + 1));

    // Back-to-back branches, then mid-run reset at pc_reg = 0xC
    step("bb0", 1'b1, 1'b0, 1'b1, 32'h4);
    step("bb1", 1'b1, 1'b0, 1'b1, 32'h8);
    chk("bb1_valid", {31'b0, valid}, 32'h0);
    step("bb_next", 1'b1, 1'b0, 1'b0, '0);
    chk("bb_next_instr", instr, 32'h33333333);
    step("midrst", 1'b0, 1'b0, 1'b0, '0);
    chk("midrst_instr", instr, 32'h0); chk("midrst_mem_addr", mem_addr, 32'h0);
    step("postrst", 1'b1, 1'b0, 1'b0, '0);
    chk("postrst_instr", instr, 32'h11111111);

    // PC wrap at the top of the address space
    step("wrap_br", 1'b1, 1'b0, 1'b1, 32'hFFFFFFFC);
    step("wrap", 1'b1, 1'b0, 1'b0, '0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_mem_addr", mem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
